blt: RTL and testbench

//   Branch lookup table (branch target buffer) for the fetch stage.
//   - Fetch presents the current pc and gets a predicted target plus a take/no-take flag in the same cycle.
//   - The branch unit in EX writes back the resolved outcome (taken/not-taken, target) of every conditional branch and JR.
//   - Fully associative, with a 2-bit saturating confidence counter per entry.

---
 rtl/blt_pkg.sv | 22 ++
 rtl/blt_entry.sv | 53 +++++
 rtl/blt.sv | 89 ++++++++
 tb/tb_blt.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/blt_pkg.sv
// Shared types and helpers for the branch lookup table.
// Counter encodings double as the take/no-take predictor: bit 1 set means predict taken.
package blt_pkg;

    localparam int BLT_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } cnt_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == STRONG_T) ? STRONG_T : cnt_t'(c + 2'd1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == STRONG_NT) ? STRONG_NT : cnt_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/blt_entry.sv
// One branch lookup table entry: key/target/confidence registers and both key compares.
module blt_entry
    import blt_pkg::*;
#(
    parameter int ADDR_WIDTH = BLT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_key,
    input  logic [ADDR_WIDTH-1:0] write_val,
    input  logic                  hit,
    input  logic                  alloc,
    input  logic [ADDR_WIDTH-1:0] read_key,
    output logic                  valid,
    output logic                  read_match,
    output logic                  write_match,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] val
);

    logic [ADDR_WIDTH-1:0] key;
    cnt_t                  cnt;

    assign read_match  = valid && (key == read_key);
    assign write_match = valid && (key == write_key);
    assign taken       = cnt[1];

    // alloc is only raised by the top when no entry matches write_key
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            key   <= '0;
            val   <= '0;
            cnt   <= STRONG_NT;
        end else if (write) begin
            if (write_match) begin
                if (hit) begin
                    val <= write_val;
                    cnt <= sat_inc(cnt);
                end else begin
                    cnt <= sat_dec(cnt);
                end
            end else if (alloc) begin
                valid <= 1'b1;
                key   <= write_key;
                val   <= write_val;
                cnt   <= WEAK_T;
            end
        end
    end

endmodule

// File: rtl/blt.sv
// Fully associative branch lookup table for fetch: zero-latency predict, EX-stage update.
// Free slots fill lowest-index first; once full, entries are evicted round-robin by rp.
module blt
    import blt_pkg::*;
#(
    parameter int ADDR_WIDTH = BLT_ADDR_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_key,
    input  logic [ADDR_WIDTH-1:0] write_val,
    input  logic                  hit,
    input  logic [ADDR_WIDTH-1:0] read_key,
    output logic [ADDR_WIDTH-1:0] read_val,
    output logic                  read_valid
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      valid_vec;
    logic [DEPTH-1:0]      rmatch;
    logic [DEPTH-1:0]      wmatch;
    logic [DEPTH-1:0]      taken;
    logic [DEPTH-1:0]      alloc_vec;
    logic [ADDR_WIDTH-1:0] val_arr [DEPTH];

    logic [IDX_W-1:0]      rp;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  any_free;
    logic                  do_alloc;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        blt_entry #(.ADDR_WIDTH(ADDR_WIDTH)) u_entry (
            .clk         (clk),
            .reset       (reset),
            .write       (write),
            .write_key   (write_key),
            .write_val   (write_val),
            .hit         (hit),
            .alloc       (alloc_vec[g]),
            .read_key    (read_key),
            .valid       (valid_vec[g]),
            .read_match  (rmatch[g]),
            .write_match (wmatch[g]),
            .taken       (taken[g]),
            .val         (val_arr[g])
        );
    end

    // Scan from the top so the lowest invalid index wins.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign do_alloc  = write && hit && !(|wmatch);
    assign alloc_idx = any_free ? free_idx : rp;
    assign alloc_vec = do_alloc ? (DEPTH'(1) << alloc_idx) : '0;

    // Keys are unique, so the one-hot OR-mux never merges two entries.
    always_comb begin
        read_val   = '0;
        read_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rmatch[i]) begin
                read_val   = read_val | val_arr[i];
                read_valid = read_valid | taken[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp <= '0;
        end else if (do_alloc && !any_free) begin
            rp <= rp + 1'b1;
        end
    end

endmodule

// File: tb/tb_blt.sv
// Randomized and directed checks of blt against a behavioural table model.
module tb_blt;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write = 1'b0;
    logic [15:0] write_key = '0;
    logic [15:0] write_val = '0;
    logic        hit = 1'b0;
    logic [15:0] read_key = '0;
    logic [15:0] read_val;
    logic        read_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic        m_valid [8];
    logic [15:0] m_key   [8];
    logic [15:0] m_val   [8];
    int          m_cnt   [8];
    int          m_rp;

    logic [15:0] last_rv;
    logic        last_rvd;

    blt #(.ADDR_WIDTH(16), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .write_key  (write_key),
        .write_val  (write_val),
        .hit        (hit),
        .read_key   (read_key),
        .read_val   (read_val),
        .read_valid (read_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_val[i]   = '0;
            m_cnt[i]   = 0;
        end
        m_rp = 0;
    endtask

    task automatic model_lookup(input logic [15:0] k, output logic vld, output logic [15:0] v);
        vld = 1'b0;
        v   = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_key[i] == k) begin
                vld = (m_cnt[i] >= 2);
                v   = m_val[i];
            end
        end
    endtask

    task automatic model_write(input logic [15:0] k, input logic [15:0] v, input logic h);
        int idx;
        idx = -1;
        for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_key[i] == k) idx = i;
        if (idx >= 0) begin
            if (h) begin
                m_val[idx] = v;
                m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            end else begin
                m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            end
        end else if (h) begin
            for (int i = 7; i >= 0; i--)
                if (!m_valid[i]) idx = i;
            if (idx < 0) begin
                idx  = m_rp;
                m_rp = (m_rp + 1) % 8;
            end
            m_valid[idx] = 1'b1;
            m_key[idx]   = k;
            m_val[idx]   = v;
            m_cnt[idx]   = 2;
        end
    endtask

    // One cycle: drive, check the pre-edge read against the model, then clock the update in.
    task automatic step(input logic w, input logic [15:0] k, input logic [15:0] v,
                        input logic h, input logic [15:0] rk);
        logic        evld;
        logic [15:0] ev;
        @(negedge clk);
        write = w; write_key = k; write_val = v; hit = h; read_key = rk;
        #1;
        model_lookup(rk, evld, ev);
        last_rv  = read_val;
        last_rvd = read_valid;
        chk("read_valid", 32'(read_valid), 32'(evld));
        chk("read_val", 32'(read_val), 32'(ev));
        @(posedge clk);
        if (w) model_write(k, v, h);
        #1;
        write = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [15:0] rk,
                             input logic evld, input logic [15:0] ev);
        @(negedge clk);
        write = 1'b0; read_key = rk;
        #1;
        chk({tag, "_valid"}, 32'(read_valid), 32'(evld));
        chk({tag, "_val"}, 32'(read_val), 32'(ev));
    endtask

    initial begin
        model_reset();
        #12 reset = 1'b1;

        // reset state
        rd_expect("reset_miss", 16'h0010, 1'b0, 16'h0000);

        // allocate
        step(1'b1, 16'h0010, 16'h0040, 1'b1, 16'h0010);
        rd_expect("alloc", 16'h0010, 1'b1, 16'h0040);

        // counter walk-down and back up
        step(1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0010);
        rd_expect("cnt1", 16'h0010, 1'b0, 16'h0040);
        step(1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0010);
        step(1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0010);
        rd_expect("cnt0_sat", 16'h0010, 1'b0, 16'h0040);
        step(1'b1, 16'h0010, 16'h0040, 1'b1, 16'h0010);
        rd_expect("cnt1_up", 16'h0010, 1'b0, 16'h0040);
        step(1'b1, 16'h0010, 16'h0040, 1'b1, 16'h0010);
        rd_expect("cnt2_up", 16'h0010, 1'b1, 16'h0040);

        // target update, same-cycle read sees old value
        step(1'b1, 16'h0010, 16'h0080, 1'b1, 16'h0010);
        chk("same_cycle_val", 32'(last_rv), 32'h0040);
        rd_expect("new_target", 16'h0010, 1'b1, 16'h0080);

        // async reset between edges
        @(negedge clk);
        read_key = 16'h0010;
        #1;
        chk("pre_reset_valid", 32'(read_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_valid", 32'(read_valid), 32'h0);
        chk("async_reset_val", 32'(read_val), 32'h0);
        model_reset();
        #3 reset = 1'b1;
        rd_expect("post_reset", 16'h0010, 1'b0, 16'h0000);

        // fill, then evict round-robin
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1, 16'h0000);
        step(1'b1, 16'h0200, 16'h2000, 1'b1, 16'h0100);
        rd_expect("evict0_gone", 16'h0100, 1'b0, 16'h0000);
        rd_expect("evict0_new", 16'h0200, 1'b1, 16'h2000);
        for (int i = 1; i < 8; i++)
            rd_expect("fill_keep", 16'h0100 + 16'(i), 1'b1, 16'h1000 + 16'(i));
        step(1'b1, 16'h0201, 16'h2001, 1'b1, 16'h0101);
        rd_expect("evict1_gone", 16'h0101, 1'b0, 16'h0000);
        rd_expect("evict1_new", 16'h0201, 1'b1, 16'h2001);

        // key 0 is legal
        step(1'b1, 16'h0000, 16'h1234, 1'b1, 16'h0000);
        rd_expect("key0", 16'h0000, 1'b1, 16'h1234);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk);
                #2 reset = 1'b0;
                model_reset();
                #2 reset = 1'b1;
            end
            step($urandom_range(0, 3) != 0,
                 16'($urandom_range(0, 11)),
                 16'($urandom),
                 $urandom_range(0, 3) != 0,
                 16'($urandom_range(0, 12)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
